// File: rtl/param_stack_reducer.sv
// LIFO stack fed by command bursts; after each burst it strobes out
// the SUM or MAX of the live entries plus an overflow/underflow flag.
module param_stack_reducer #(
  parameter  int DATA_W = 4,
  parameter  int DEPTH  = 4,
  localparam int CNT_W  = $clog2(DEPTH + 1),
  localparam int OUT_W  = DATA_W + $clog2(DEPTH)
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              IN_VALID,
  input  logic [1:0]        OP,
  input  logic [DATA_W-1:0] IN,
  input  logic              MODE,
  output logic [OUT_W-1:0]  OUT,
  output logic              OUT_VALID,
  output logic              ERR,
  output logic [CNT_W-1:0]  COUNT,
  output logic              FULL,
  output logic              EMPTY
);

  localparam int AW = $clog2(DEPTH);

  localparam logic [1:0] OP_POP  = 2'b00;
  localparam logic [1:0] OP_PUSH = 2'b01;
  localparam logic [1:0] OP_REPL = 2'b10;
  localparam logic [1:0] OP_CLR  = 2'b11;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] mem_d [DEPTH];
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              pend_q, pend_d;
  logic              acc_q, acc_d;
  logic              ov_q, ov_d;
  logic              err_q, err_d;
  logic [OUT_W-1:0]  out_q, out_d;

  logic [OUT_W-1:0]  sum_c, max_c;
  logic [CNT_W-1:0]  cnt_m1;
  logic [AW-1:0]     wr_idx, top_idx;
  logic              full_c, empty_c, trig_c;

  assign full_c  = (cnt_q == CNT_W'(DEPTH));
  assign empty_c = (cnt_q == '0);
  assign cnt_m1  = cnt_q - CNT_W'(1);
  assign wr_idx  = cnt_q[AW-1:0];
  assign top_idx = cnt_m1[AW-1:0];
  assign trig_c  = !IN_VALID && pend_q;

  // Vacated slots are kept at zero, so reducing every slot is exact.
  always_comb begin
    sum_c = '0;
    max_c = '0;
    for (int i = 0; i < DEPTH; i++) begin
      sum_c = sum_c + OUT_W'(mem_q[i]);
      if (OUT_W'(mem_q[i]) > max_c) max_c = OUT_W'(mem_q[i]);
    end
  end

  always_comb begin
    mem_d  = mem_q;
    cnt_d  = cnt_q;
    pend_d = pend_q;
    acc_d  = acc_q;
    ov_d   = 1'b0;
    err_d  = 1'b0;
    out_d  = '0;
    if (trig_c) begin
      pend_d = 1'b0;
      acc_d  = 1'b0;
      if (!empty_c || acc_q) begin
        ov_d  = 1'b1;
        err_d = acc_q;
        out_d = MODE ? max_c : sum_c;
      end
    end
    if (IN_VALID) begin
      pend_d = 1'b1;
      unique case (OP)
        OP_POP: begin
          if (empty_c) begin
            acc_d = 1'b1;
          end else begin
            cnt_d          = cnt_m1;
            mem_d[top_idx] = '0;
          end
        end
        OP_PUSH: begin
          if (full_c) begin
            acc_d = 1'b1;
          end else begin
            cnt_d         = cnt_q + CNT_W'(1);
            mem_d[wr_idx] = IN;
          end
        end
        OP_REPL: begin
          if (empty_c) acc_d = 1'b1;
          else mem_d[top_idx] = IN;
        end
        OP_CLR: begin
          cnt_d = '0;
          for (int i = 0; i < DEPTH; i++) mem_d[i] = '0;
        end
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (!RESET) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      cnt_q  <= '0;
      pend_q <= 1'b0;
      acc_q  <= 1'b0;
      ov_q   <= 1'b0;
      err_q  <= 1'b0;
      out_q  <= '0;
    end else begin
      mem_q  <= mem_d;
      cnt_q  <= cnt_d;
      pend_q <= pend_d;
      acc_q  <= acc_d;
      ov_q   <= ov_d;
      err_q  <= err_d;
      out_q  <= out_d;
    end
  end

  assign OUT       = out_q;
  assign OUT_VALID = ov_q;
  assign ERR       = err_q;
  assign COUNT     = cnt_q;
  assign FULL      = full_c;
  assign EMPTY     = empty_c;

endmodule
